// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 peripheral register controller: synchronizes the SPI pins into clk, decodes
// 16-bit write frames into five config registers. Optional read-back via SPI_READBACK_EN.
module spi_reg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       txn_err
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(17);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;

  logic                   w_sclk_s;
  logic                   w_ncs_s;
  logic                   w_copi_s;
  logic                   w_sclk_rise;
  logic                   w_ncs_fall;
  logic                   w_ncs_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_start;
  logic                   w_shift;
  logic                   w_commit;

  logic [FRAME_W-1:0]     r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [7:0]             r_reg_out_lo;
  logic [7:0]             r_reg_out_hi;
  logic [7:0]             r_reg_pwm_lo;
  logic [7:0]             r_reg_pwm_hi;
  logic [7:0]             r_reg_duty;
  logic                   r_txn_done;
  logic                   r_txn_err;

  logic                   w_full;
  logic                   w_is_write;
  logic [6:0]             w_addr;
  logic [7:0]             w_data;
  logic                   w_addr_ok;
  logic                   w_wr_ok;
  logic                   w_frame_bad;

  // Input synchronizers plus one extra flop per edge-detected line; ncs idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_prev <= w_sclk_s;
      r_ncs_prev  <= w_ncs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev & ~w_ncs_s;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) w_state_nxt = ST_COMMIT;
        else            w_shift     = w_sclk_rise;
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_full      = (r_bit_cnt == CNT_FULL);
  assign w_is_write  = r_shift[15];
  assign w_addr      = r_shift[14:8];
  assign w_data      = r_shift[7:0];
  assign w_addr_ok   = (w_addr <= MAX_ADDR);
  assign w_wr_ok     = w_full & w_is_write & w_addr_ok;
  assign w_frame_bad = ~w_full | (w_is_write & ~w_addr_ok);

  // Shift register, saturating bit counter, register file and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_reg_out_lo <= '0;
      r_reg_out_hi <= '0;
      r_reg_pwm_lo <= '0;
      r_reg_pwm_hi <= '0;
      r_reg_duty   <= '0;
      r_txn_done   <= 1'b0;
      r_txn_err    <= 1'b0;
    end else begin
      r_txn_done <= 1'b0;
      r_txn_err  <= 1'b0;
      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_copi_s};
        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_commit) begin
        if (w_wr_ok) begin
          r_txn_done <= 1'b1;
          case (w_addr)
            7'h00:   r_reg_out_lo <= w_data;
            7'h01:   r_reg_out_hi <= w_data;
            7'h02:   r_reg_pwm_lo <= w_data;
            7'h03:   r_reg_pwm_hi <= w_data;
            7'h04:   r_reg_duty   <= w_data;
            default: ;
          endcase
        end else if (w_frame_bad) begin
          r_txn_err <= 1'b1;
        end
      end
    end
  end

  assign en_reg_out_7_0  = r_reg_out_lo;
  assign en_reg_out_15_8 = r_reg_out_hi;
  assign en_reg_pwm_7_0  = r_reg_pwm_lo;
  assign en_reg_pwm_15_8 = r_reg_pwm_hi;
  assign pwm_duty_cycle  = r_reg_duty;
  assign txn_done        = r_txn_done;
  assign txn_err         = r_txn_err;

`ifdef SPI_READBACK_EN
  logic       w_sclk_fall;
  logic [6:0] w_rd_addr;
  logic [7:0] r_shadow;

  function automatic logic [7:0] f_reg_sel(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a <= MAX_ADDR) begin
      case (a)
        7'h00:   v = r_reg_out_lo;
        7'h01:   v = r_reg_out_hi;
        7'h02:   v = r_reg_pwm_lo;
        7'h03:   v = r_reg_pwm_hi;
        7'h04:   v = r_reg_duty;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev & ~w_ncs_s;
  // Address is complete on the 8th rise: seven bits already shifted plus the incoming one.
  assign w_rd_addr   = {r_shift[5:0], w_copi_s};

  // Bit 7 stays on cipo until the host samples it on the 9th rise; later falls advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (r_state != ST_SHIFT || w_ncs_s) begin
      r_shadow <= '0;
    end else if (w_shift && r_bit_cnt == CNT_W'(7) && !r_shift[6]) begin
      r_shadow <= f_reg_sel(w_rd_addr);
    end else if (w_sclk_fall && r_bit_cnt >= CNT_W'(9)) begin
      r_shadow <= {r_shadow[6:0], 1'b0};
    end
  end

  assign cipo = r_shadow[7];
`else
  assign cipo = 1'b0;
`endif

endmodule
